// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS-style control unit.
// Optional feature: define MULTICYCLE_ADDI_EN to add the addi (0x08) states.
package mc_ctrl_pkg;

  // Control states. The addi states exist only when MULTICYCLE_ADDI_EN is set.
  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXECUTE   = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9
`ifdef MULTICYCLE_ADDI_EN
    ,
    ADDI_EX   = 4'd10,
    ADDI_WB   = 4'd11
`endif
  } state_e;

  // Instruction opcode field values.
  localparam logic [5:0] R_TYPE = 6'h00;
  localparam logic [5:0] LW     = 6'h23;
  localparam logic [5:0] SW     = 6'h2B;
  localparam logic [5:0] BEQ    = 6'h04;
  localparam logic [5:0] J      = 6'h02;
  localparam logic [5:0] ADDI   = 6'h08;

  // ALU operation selects.
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  // PC source mux selects.
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALU B operand mux selects.
  localparam logic [1:0] ALUSRCB_REG      = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR     = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM      = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SHL2 = 2'b11;

  // Datapath control bundle produced by the output decoder.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state + mem_ready to datapath-control decoder.
// Optional feature: MULTICYCLE_ADDI_EN adds the ADDI_EX / ADDI_WB decodes.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic [STATE_W-1:0] state_i,
  input  logic               mem_ready_i,
  output ctrl_t              ctrl_o
);

  logic st_known;

  // Encodings with any bit above the enum width set can never be entered.
  always_comb st_known = ((state_i >> 4) == '0);

  // Moore outputs per state; mem_ready only qualifies fetch and store completion.
  always_comb begin
    ctrl_o = '0;
    if (st_known) begin
      case (state_e'(state_i[3:0]))
        FETCH: begin
          ctrl_o.mem_read  = 1'b1;
          ctrl_o.alu_src_b = ALUSRCB_FOUR;
          ctrl_o.alu_op    = ALUOP_ADD;
          ctrl_o.pc_source = PCSRC_ALU;
          ctrl_o.ir_write  = mem_ready_i;
          ctrl_o.pc_write  = mem_ready_i;
        end
        DECODE: begin
          ctrl_o.alu_src_b = ALUSRCB_IMM_SHL2;
        end
        MEM_ADDR: begin
          ctrl_o.alu_src_a = 1'b1;
          ctrl_o.alu_src_b = ALUSRCB_IMM;
        end
        MEM_READ: begin
          ctrl_o.mem_read = 1'b1;
          ctrl_o.ior_d    = 1'b1;
        end
        MEM_WB: begin
          ctrl_o.reg_write  = 1'b1;
          ctrl_o.mem_to_reg = 1'b1;
          ctrl_o.instr_done = 1'b1;
        end
        MEM_WRITE: begin
          ctrl_o.mem_write  = 1'b1;
          ctrl_o.ior_d      = 1'b1;
          ctrl_o.instr_done = mem_ready_i;
        end
        EXECUTE: begin
          ctrl_o.alu_src_a = 1'b1;
          ctrl_o.alu_src_b = ALUSRCB_REG;
          ctrl_o.alu_op    = ALUOP_FUNC;
        end
        R_WB: begin
          ctrl_o.reg_write  = 1'b1;
          ctrl_o.reg_dst    = 1'b1;
          ctrl_o.instr_done = 1'b1;
        end
        BRANCH: begin
          ctrl_o.alu_src_a     = 1'b1;
          ctrl_o.alu_op        = ALUOP_SUB;
          ctrl_o.pc_write_cond = 1'b1;
          ctrl_o.pc_source     = PCSRC_ALUOUT;
          ctrl_o.instr_done    = 1'b1;
        end
        JUMP: begin
          ctrl_o.pc_write   = 1'b1;
          ctrl_o.pc_source  = PCSRC_JUMP;
          ctrl_o.instr_done = 1'b1;
        end
`ifdef MULTICYCLE_ADDI_EN
        ADDI_EX: begin
          ctrl_o.alu_src_a = 1'b1;
          ctrl_o.alu_src_b = ALUSRCB_IMM;
        end
        ADDI_WB: begin
          ctrl_o.reg_write  = 1'b1;
          ctrl_o.instr_done = 1'b1;
        end
`endif
        default: ctrl_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control unit: state register, next-state logic and output gating.
// Optional feature: define MULTICYCLE_ADDI_EN to support addi (0x08);
// otherwise 0x08 decodes as an illegal opcode.
// Memory handshake: mem_ready=1 in a memory state means the access completes
// in this cycle and the FSM advances on the next rising edge; mem_ready=0
// holds the FSM in that state with its outputs unchanged.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic               ALUSrcA,
  output logic               RegWrite,
  output logic               RegDst,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [STATE_W-1:0] dbg_state
);

  if (STATE_W < 4) begin : g_bad_state_w
    $error("multicycle_control: STATE_W must be at least 4");
  end

  logic [STATE_W-1:0] state_q, state_d;
  logic               is_sw_q, is_sw_d;
  logic               illegal_dec;
  ctrl_t              ctrl_dec;
  ctrl_t              ctrl_out;

  // State register; reset lands in FETCH immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= STATE_W'(FETCH);
      is_sw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_sw_q <= is_sw_d;
    end
  end

  // Next-state selection; opcode is captured (store vs load) only in DECODE.
  always_comb begin
    state_d     = STATE_W'(FETCH);
    is_sw_d     = is_sw_q;
    illegal_dec = 1'b0;
    if ((state_q >> 4) == '0) begin
      case (state_e'(state_q[3:0]))
        FETCH:     state_d = mem_ready ? STATE_W'(DECODE) : STATE_W'(FETCH);
        DECODE: begin
          is_sw_d = (opcode == SW);
          case (opcode)
            R_TYPE:  state_d = STATE_W'(EXECUTE);
            LW, SW:  state_d = STATE_W'(MEM_ADDR);
            BEQ:     state_d = STATE_W'(BRANCH);
            J:       state_d = STATE_W'(JUMP);
`ifdef MULTICYCLE_ADDI_EN
            ADDI:    state_d = STATE_W'(ADDI_EX);
`endif
            default: begin
              state_d     = STATE_W'(FETCH);
              illegal_dec = 1'b1;
            end
          endcase
        end
        MEM_ADDR:  state_d = is_sw_q ? STATE_W'(MEM_WRITE) : STATE_W'(MEM_READ);
        MEM_READ:  state_d = mem_ready ? STATE_W'(MEM_WB) : STATE_W'(MEM_READ);
        MEM_WRITE: state_d = mem_ready ? STATE_W'(FETCH) : STATE_W'(MEM_WRITE);
        EXECUTE:   state_d = STATE_W'(R_WB);
`ifdef MULTICYCLE_ADDI_EN
        ADDI_EX:   state_d = STATE_W'(ADDI_WB);
`endif
        default:   state_d = STATE_W'(FETCH);
      endcase
    end
  end

  mc_ctrl_decode #(
    .STATE_W (STATE_W)
  ) u_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl_dec)
  );

  // Reset silences every output combinationally, without waiting for clk.
  always_comb ctrl_out = rst ? '0 : ctrl_dec;

  assign PCWrite     = ctrl_out.pc_write;
  assign PCWriteCond = ctrl_out.pc_write_cond;
  assign IorD        = ctrl_out.ior_d;
  assign MemRead     = ctrl_out.mem_read;
  assign MemWrite    = ctrl_out.mem_write;
  assign MemtoReg    = ctrl_out.mem_to_reg;
  assign IRWrite     = ctrl_out.ir_write;
  assign ALUSrcA     = ctrl_out.alu_src_a;
  assign RegWrite    = ctrl_out.reg_write;
  assign RegDst      = ctrl_out.reg_dst;
  assign PCSource    = ctrl_out.pc_source;
  assign ALUSrcB     = ctrl_out.alu_src_b;
  assign ALUOp       = ctrl_out.alu_op;
  assign instr_done  = ctrl_out.instr_done;
  assign illegal_op  = illegal_dec & ~rst;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control (build with or without
// MULTICYCLE_ADDI_EN). The reference model tracks only the instruction kind
// and the cycle position inside the instruction.
module tb_multicycle_control;
  import mc_ctrl_pkg::*;

  localparam int STATE_W = 4;

  // Bit positions in the packed output vector.
  localparam int B_PCW  = 17;
  localparam int B_PCWC = 16;
  localparam int B_IORD = 15;
  localparam int B_MRD  = 14;
  localparam int B_MWR  = 13;
  localparam int B_M2R  = 12;
  localparam int B_IRW  = 11;
  localparam int B_ASA  = 10;
  localparam int B_RW   = 9;
  localparam int B_RD   = 8;
  localparam int B_DONE = 1;
  localparam int B_ILL  = 0;

  // Instruction kinds for the model.
  localparam int K_RT   = 0;
  localparam int K_LW   = 1;
  localparam int K_SW   = 2;
  localparam int K_BEQ  = 3;
  localparam int K_J    = 4;
  localparam int K_ADDI = 5;
  localparam int K_ILL  = 6;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst;
  logic [5:0] opcode;
  logic mem_ready;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic ALUSrcA, RegWrite, RegDst, instr_done, illegal_op;
  logic [1:0] PCSource, ALUSrcB, ALUOp;
  logic [STATE_W-1:0] dbg_state;
  logic [17:0] dut_vec;

  always #5 clk = ~clk;

  multicycle_control #(.STATE_W(STATE_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .instr_done(instr_done), .illegal_op(illegal_op), .dbg_state(dbg_state)
  );

  assign dut_vec = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                    IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB,
                    ALUOp, instr_done, illegal_op};

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  function automatic int classify(input logic [5:0] op);
    case (op)
      6'h00:   return K_RT;
      6'h23:   return K_LW;
      6'h2B:   return K_SW;
      6'h04:   return K_BEQ;
      6'h02:   return K_J;
`ifdef MULTICYCLE_ADDI_EN
      6'h08:   return K_ADDI;
`endif
      default: return K_ILL;
    endcase
  endfunction

  // Total cycles of each instruction with no memory stalls.
  function automatic int kind_len(input int k);
    case (k)
      K_RT, K_SW, K_ADDI: return 4;
      K_LW:               return 5;
      K_BEQ, K_J:         return 3;
      default:            return 2;
    endcase
  endfunction

  // Positions that are memory accesses and stall on mem_ready=0.
  function automatic logic waits_on_mem(input int k, input int pos);
    return (pos == 0) || (pos == 3 && (k == K_LW || k == K_SW));
  endfunction

  function automatic logic [17:0] model_out(input int k, input int pos, input logic mr);
    logic [17:0] v;
    v = '0;
    case (pos)
      0: begin
        v[B_MRD] = 1'b1; v[5:4] = 2'b01; v[B_IRW] = mr; v[B_PCW] = mr;
      end
      1: begin
        v[5:4] = 2'b11; v[B_ILL] = (k == K_ILL);
      end
      2: case (k)
        K_RT:               begin v[B_ASA] = 1'b1; v[3:2] = 2'b10; end
        K_LW, K_SW, K_ADDI: begin v[B_ASA] = 1'b1; v[5:4] = 2'b10; end
        K_BEQ: begin
          v[B_ASA] = 1'b1; v[3:2] = 2'b01; v[B_PCWC] = 1'b1;
          v[7:6] = 2'b01; v[B_DONE] = 1'b1;
        end
        K_J: begin v[B_PCW] = 1'b1; v[7:6] = 2'b10; v[B_DONE] = 1'b1; end
        default: ;
      endcase
      3: case (k)
        K_RT:   begin v[B_RW] = 1'b1; v[B_RD] = 1'b1; v[B_DONE] = 1'b1; end
        K_LW:   begin v[B_MRD] = 1'b1; v[B_IORD] = 1'b1; end
        K_SW:   begin v[B_MWR] = 1'b1; v[B_IORD] = 1'b1; v[B_DONE] = mr; end
        K_ADDI: begin v[B_RW] = 1'b1; v[B_DONE] = 1'b1; end
        default: ;
      endcase
      4: if (k == K_LW) begin
        v[B_RW] = 1'b1; v[B_M2R] = 1'b1; v[B_DONE] = 1'b1;
      end
      default: ;
    endcase
    return v;
  endfunction

  // ---------------- scoreboard: compare every cycle ----------------
  logic [17:0] exp_q[$];
  int m_pos  = 0;
  int m_kind = K_ILL;

  always @(negedge clk) begin
    int k;
    logic [17:0] expv;
    if (rst) begin
      exp_q.push_back('0);
      m_pos = 0;
    end else begin
      k = (m_pos == 1) ? classify(opcode) : m_kind;
      exp_q.push_back(model_out(k, m_pos, mem_ready));
      if (m_pos == 1) m_kind = k;
      if (waits_on_mem(k, m_pos) && !mem_ready) m_pos = m_pos;
      else if (m_pos == kind_len(k) - 1)         m_pos = 0;
      else                                       m_pos = m_pos + 1;
    end
    expv = exp_q.pop_front();
    checks++;
    if (dut_vec !== expv) begin
      failures++;
      $display("FAIL cycle_model t=%0t got=%05h exp=%05h", $time, dut_vec, expv);
    end
  end

  // ---------------- driver tasks ----------------
  logic [17:0]        snap_vec;
  logic [STATE_W-1:0] snap_state;

  task automatic cyc(input logic mr, input logic [5:0] op);
    opcode    = op;
    mem_ready = mr;
    @(negedge clk);
    snap_vec   = dut_vec;
    snap_state = dbg_state;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    state_e     rt_states[4];
    logic       lw_mr[8];
    logic [5:0] op_pool[6];
    int cnt_a, cnt_b, done_at;

    rt_states = '{FETCH, DECODE, EXECUTE, R_WB};
    lw_mr     = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    op_pool   = '{R_TYPE, LW, SW, BEQ, J, ADDI};

    // Reset holds everything low, including MemRead.
    rst = 1'b1; opcode = '0; mem_ready = 1'b0;
    @(negedge clk);
    chk("reset_outputs", 32'(dut_vec), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'(FETCH));
    @(posedge clk); #1;
    rst = 1'b0;

    // R-type with mem_ready=1.
    cnt_a = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, R_TYPE);
      chk("rt_state", 32'(snap_state), 32'(rt_states[i]));
      cnt_a += int'(snap_vec[B_DONE]);
    end
    chk("rt_c4_regwrite", 32'(snap_vec[B_RW]), 32'd1);
    chk("rt_c4_regdst", 32'(snap_vec[B_RD]), 32'd1);
    chk("rt_done_count", 32'(cnt_a), 32'd1);

    // lw with three stalled MEM_READ cycles.
    cnt_a = 0; cnt_b = 0; done_at = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(lw_mr[i], LW);
      cnt_a += int'(snap_vec[B_MRD] & snap_vec[B_IORD]);
      cnt_b += int'(snap_vec[B_RW]);
      if (snap_vec[B_DONE] && done_at == 0) done_at = i + 1;
    end
    chk("lw_memread_iord_cycles", 32'(cnt_a), 32'd4);
    chk("lw_regwrite_count", 32'(cnt_b), 32'd1);
    chk("lw_latency", 32'(done_at), 32'd8);

    // FETCH stalled for two cycles, then a beq.
    cnt_a = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(i >= 2, BEQ);
      if (i < 2) begin
        chk("fetch_wait_pcwrite", 32'(snap_vec[B_PCW]), 32'd0);
        chk("fetch_wait_irwrite", 32'(snap_vec[B_IRW]), 32'd0);
      end
      cnt_a += int'(snap_vec[B_PCW]);
    end
    chk("fetch_pcwrite_pulses", 32'(cnt_a), 32'd1);
    chk("beq_done_cycle3", 32'(snap_vec[B_DONE]), 32'd1);

    // Unsupported opcode 0x3F.
    cyc(1'b1, 6'h3F);
    cyc(1'b1, 6'h3F);
    chk("ill_pulse", 32'(snap_vec[B_ILL]), 32'd1);
    chk("ill_no_writes", 32'({snap_vec[B_PCW], snap_vec[B_PCWC], snap_vec[B_MWR],
                              snap_vec[B_RW], snap_vec[B_IRW]}), 32'd0);
    cyc(1'b0, R_TYPE);
    chk("ill_next_fetch", 32'(snap_state), 32'(FETCH));

    // Reset in the middle of a stalled store.
    cyc(1'b1, SW); cyc(1'b1, SW); cyc(1'b1, SW);
    opcode = SW; mem_ready = 1'b0;
    @(negedge clk);
    chk("sw_memwrite_active", 32'(dut_vec[B_MWR]), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_memwrite", 32'(dut_vec[B_MWR]), 32'd0);
    chk("rst_async_all_zero", 32'(dut_vec), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk("post_rst_state", 32'(dbg_state), 32'(FETCH));
    chk("post_rst_memread", 32'(dut_vec[B_MRD]), 32'd1);
    @(posedge clk); #1;

    // addi, with or without the optional states.
    cyc(1'b1, ADDI);
    cyc(1'b1, ADDI);
`ifdef MULTICYCLE_ADDI_EN
    chk("addi_decode_legal", 32'(snap_vec[B_ILL]), 32'd0);
    cyc(1'b1, ADDI);
    cyc(1'b1, ADDI);
    chk("addi_c4_regwrite", 32'(snap_vec[B_RW]), 32'd1);
    chk("addi_c4_regdst", 32'(snap_vec[B_RD]), 32'd0);
    chk("addi_c4_done", 32'(snap_vec[B_DONE]), 32'd1);
`else
    chk("addi_illegal_pulse", 32'(snap_vec[B_ILL]), 32'd1);
    cyc(1'b0, R_TYPE);
    chk("addi_next_fetch", 32'(snap_state), 32'(FETCH));
`endif

    // Randomized traffic with occasional resets; checked by the scoreboard.
    for (int n = 0; n < 600; n++) begin
      int idx;
      logic [5:0] op;
      idx = $urandom_range(0, 7);
      op  = (idx < 6) ? op_pool[idx] : 6'($urandom_range(0, 63));
      rst = ($urandom_range(0, 50) == 0);
      cyc($urandom_range(0, 3) != 0, op);
      rst = 1'b0;
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
